seq_divider4: RTL

Sequential unsigned 4-bit restoring divider that drives the team's existing 4-bit ripple add/sub unit (`FBAddSub`) as its only arithmetic resource. It accepts a start pulse with dividend and divisor, runs one subtract-and-restore iteration per clock, then presents quotient and remainder with a one-cycle done pulse. It sits beside the add/sub lab datapath as its sequencing controller.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider4_fbaddsub.sv | 26 ++
 rtl/seq_divider4.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared widths and FSM encoding for seq_divider4.
// Optional divide-by-zero trap: SEQ_DIVIDER4_DIV_ZERO_TRAP_EN.
package seq_divider_pkg;

  localparam int WIDTH      = 4;
  localparam int ITER_COUNT = 4;

  localparam logic [1:0] LAST_ITER = 2'(ITER_COUNT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/seq_divider4_fbaddsub.sv
// FBAddSub: 4-bit ripple adder/subtractor, s = x + (y ^ k) + k.
// cout is the final carry; with k=1 it means "no borrow".
module FBAddSub (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       k,
  output logic [3:0] s,
  output logic       cout
);

  logic c;
  logic yb;

  always_comb begin
    s  = '0;
    c  = k;
    yb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      yb   = y[i] ^ k;
      s[i] = x[i] ^ yb ^ c;
      c    = (x[i] & yb) | (c & (x[i] ^ yb));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_divider4.sv
// seq_divider4: sequential 4-bit restoring divider on FBAddSub.
// SEQ_DIVIDER4_DIV_ZERO_TRAP_EN: divisor=0 finishes after one cycle.
module seq_divider4
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = seq_divider_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [1:0]       state;
  logic [1:0]       nstate;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [1:0]       cnt;
  logic [1:0]       cnt_inc;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] diff;
  logic             cout;
  logic             accept;
  logic             zdiv;

  assign t       = {r[WIDTH-2:0], q[WIDTH-1]};
  assign cnt_inc = {cnt[1] ^ cnt[0], ~cnt[0]};
  assign accept  = start && (state != RUN);
  assign zdiv    = (divisor == '0);

  FBAddSub u_addsub (
    .x    (t),
    .y    (d),
    .k    (1'b1),
    .s    (diff),
    .cout (cout)
  );

`ifdef SEQ_DIVIDER4_DIV_ZERO_TRAP_EN
  logic dz;

  // Trapped ops spend their single RUN cycle holding the preset result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r   <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else if (accept) begin
      r   <= zdiv ? dividend : '0;
      q   <= zdiv ? '1 : dividend;
      d   <= divisor;
      cnt <= '0;
      dz  <= zdiv;
    end else if (state == RUN && !dz) begin
      r   <= cout ? diff : t;
      q   <= {q[WIDTH-2:0], cout};
      cnt <= cnt_inc;
    end
  end

  assign div_by_zero = dz;
`else
  logic dz;

  assign dz = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r   <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (accept) begin
      r   <= '0;
      q   <= dividend;
      d   <= divisor;
      cnt <= '0;
    end else if (state == RUN) begin
      r   <= cout ? diff : t;
      q   <= {q[WIDTH-2:0], cout};
      cnt <= cnt_inc;
    end
  end

  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    nstate = start ? RUN : IDLE;
      RUN:     nstate = (dz || cnt == LAST_ITER) ? DONE : RUN;
      DONE:    nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  assign quotient  = q;
  assign remainder = r;

  logic unused;
  assign unused = zdiv;

endmodule
